// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
// Multicycle control unit for the modular MIPS datapath. Sequences a separate
// state path per instruction class (R-type, immediate ALU, load, store,
// branch, jump), waits on mem_ready for memory accesses and traps unsupported
// opcodes/functs.
//
// Parameters:
//   USE_MEM_READY  - 1: FETCH/MEMRD/MEMWR wait for mem_ready; 0: never wait
//   SUPPORT_BRANCH - 1: BEQ/BNE executed; 0: they trap
//   SUPPORT_JUMP   - 1: J executed; 0: it traps
//
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   op, funct             - IR fields [31:26] and [5:0]
//   zero                  - ALU zero flag (branch resolution)
//   mem_ready             - memory completes the current access this cycle
//   iord, mem_write       - memory address select / write strobe
//   ir_write, pc_en       - IR load / final PC load
//   pc_src                - 00 ALU, 01 ALUOut, 10 jump target
//   alu_src_a, alu_src_b  - ALU operand selects
//   imm_zext              - zero-extend the immediate
//   alu_control           - ALU operation code
//   reg_write, reg_dst    - register file write / 1 = rd, 0 = rt
//   mem_to_reg            - write-back source select
//   illegal               - one-cycle unsupported-instruction pulse
//   state                 - current state (debug)
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
   parameter bit USE_MEM_READY  = 1'b1,
   parameter bit SUPPORT_BRANCH = 1'b1,
   parameter bit SUPPORT_JUMP   = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       iord,
   output logic       mem_write,
   output logic       ir_write,
   output logic       pc_en,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       imm_zext,
   output logic [2:0] alu_control,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       illegal,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_RTEXEC = 4'd7,
      S_ALUWB  = 4'd8,  S_IEXEC  = 4'd9,  S_IWB    = 4'd10, S_BRANCH = 4'd11,
      S_JUMP   = 4'd12, S_TRAP   = 4'd13
   } state_e;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SLL = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_SUB = 3'b100;
   localparam logic [2:0] ALU_LUI = 3'b101;
   localparam logic [2:0] ALU_SLT = 3'b110;

   state_e state_q, state_d;
   logic   mem_rdy_s;
   logic   pc_write_s;
   logic   branch_s;
   logic   bne_sel_s;

   // Supported R-type functs.
   function automatic logic funct_ok(input logic [5:0] f);
      case (f)
         6'h00, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: funct_ok = 1'b1;
         default:                                  funct_ok = 1'b0;
      endcase
   endfunction

   // ALU code for an R-type funct.
   function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
      case (f)
         6'h00:   alu_of_funct = ALU_SLL;
         6'h22:   alu_of_funct = ALU_SUB;
         6'h24:   alu_of_funct = ALU_AND;
         6'h25:   alu_of_funct = ALU_OR;
         6'h2A:   alu_of_funct = ALU_SLT;
         default: alu_of_funct = ALU_ADD;
      endcase
   endfunction

   // ALU code for an immediate-class opcode.
   function automatic logic [2:0] alu_of_op(input logic [5:0] o);
      case (o)
         6'h0A:   alu_of_op = ALU_SLT;
         6'h0C:   alu_of_op = ALU_AND;
         6'h0D:   alu_of_op = ALU_OR;
         6'h0F:   alu_of_op = ALU_LUI;
         default: alu_of_op = ALU_ADD;
      endcase
   endfunction

   assign mem_rdy_s = USE_MEM_READY ? mem_ready : 1'b1;

   // Next-state logic.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  state_d = mem_rdy_s ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               6'h00:                      state_d = funct_ok(funct) ? S_RTEXEC : S_TRAP;
               6'h23, 6'h2B:               state_d = S_MEMADR;
               6'h08, 6'h0A, 6'h0C,
               6'h0D, 6'h0F:               state_d = S_IEXEC;
               6'h04, 6'h05:               state_d = SUPPORT_BRANCH ? S_BRANCH : S_TRAP;
               6'h02:                      state_d = SUPPORT_JUMP ? S_JUMP : S_TRAP;
               default:                    state_d = S_TRAP;
            endcase
         end
         S_MEMADR: state_d = (op == 6'h2B) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  state_d = mem_rdy_s ? S_MEMWB : S_MEMRD;
         S_MEMWR:  state_d = mem_rdy_s ? S_FETCH : S_MEMWR;
         S_RTEXEC: state_d = S_ALUWB;
         S_IEXEC:  state_d = S_IWB;
         default:  state_d = S_FETCH;   // write-back, branch, jump, trap, codes 14-15
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Moore output decode from the current state (plus op/funct after DECODE).
   always_comb begin
      iord        = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      pc_write_s  = 1'b0;
      pc_src      = 2'b00;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      imm_zext    = 1'b0;
      alu_control = ALU_ADD;
      reg_write   = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      illegal     = 1'b0;
      branch_s    = 1'b0;
      bne_sel_s   = 1'b0;
      case (state_q)
         S_FETCH: begin
            alu_src_b  = 2'b01;
            ir_write   = mem_rdy_s;
            pc_write_s = mem_rdy_s;
         end
         S_DECODE: alu_src_b = 2'b11;   // precompute branch target into ALUOut
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMRD:  iord = 1'b1;
         S_MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
         end
         S_MEMWR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
         end
         S_RTEXEC: begin
            alu_src_a   = 1'b1;
            alu_control = alu_of_funct(funct);
         end
         S_ALUWB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
         end
         S_IEXEC: begin
            alu_src_a   = 1'b1;
            alu_src_b   = 2'b10;
            alu_control = alu_of_op(op);
            imm_zext    = (op == 6'h0C) || (op == 6'h0D);
         end
         S_IWB:    reg_write = 1'b1;
         S_BRANCH: begin
            alu_src_a   = 1'b1;
            alu_control = ALU_SUB;
            pc_src      = 2'b01;
            branch_s    = 1'b1;
            bne_sel_s   = (op == 6'h05);
         end
         S_JUMP: begin
            pc_src     = 2'b10;
            pc_write_s = 1'b1;
         end
         S_TRAP:   illegal = 1'b1;
         default: begin
            iord = 1'b0;   // IDLE and unused codes: everything stays low
         end
      endcase
   end

   assign pc_en = pc_write_s | (branch_s & (zero ^ bne_sel_s));
   assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench: the stimulus process expands each instruction into its
// expected per-cycle output record (derived from the instruction class) and
// queues it; a negedge monitor pops and compares against two DUT instances
// (all features on, and branch/jump disabled).
module tb_mips_multicycle_ctrl;

   typedef struct packed {
      logic [3:0] st;
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       pc_en;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       imm_zext;
      logic [2:0] alu_control;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       illegal;
   } rec_t;

   typedef enum int {C_R, C_LW, C_SW, C_IMM, C_BR, C_J, C_TRAP} cls_e;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] op = 6'h00;
   logic [5:0] funct = 6'h00;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;

   logic       a_iord, a_mw, a_irw, a_pcen, a_asa, a_zx, a_rw, a_rd, a_m2r, a_ill;
   logic [1:0] a_pcs, a_asb;
   logic [2:0] a_alu;
   logic [3:0] a_st;
   logic       b_iord, b_mw, b_irw, b_pcen, b_asa, b_zx, b_rw, b_rd, b_m2r, b_ill;
   logic [1:0] b_pcs, b_asb;
   logic [2:0] b_alu;
   logic [3:0] b_st;

   mips_multicycle_ctrl dut_a (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .iord(a_iord), .mem_write(a_mw), .ir_write(a_irw), .pc_en(a_pcen), .pc_src(a_pcs),
      .alu_src_a(a_asa), .alu_src_b(a_asb), .imm_zext(a_zx), .alu_control(a_alu),
      .reg_write(a_rw), .reg_dst(a_rd), .mem_to_reg(a_m2r), .illegal(a_ill), .state(a_st));

   mips_multicycle_ctrl #(.USE_MEM_READY(1'b1), .SUPPORT_BRANCH(1'b0), .SUPPORT_JUMP(1'b0)) dut_b (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .iord(b_iord), .mem_write(b_mw), .ir_write(b_irw), .pc_en(b_pcen), .pc_src(b_pcs),
      .alu_src_a(b_asa), .alu_src_b(b_asb), .imm_zext(b_zx), .alu_control(b_alu),
      .reg_write(b_rw), .reg_dst(b_rd), .mem_to_reg(b_m2r), .illegal(b_ill), .state(b_st));

   rec_t act_a, act_b;
   assign act_a = {a_st, a_iord, a_mw, a_irw, a_pcen, a_pcs, a_asa, a_asb, a_zx, a_alu, a_rw, a_rd, a_m2r, a_ill};
   assign act_b = {b_st, b_iord, b_mw, b_irw, b_pcen, b_pcs, b_asa, b_asb, b_zx, b_alu, b_rw, b_rd, b_m2r, b_ill};

   always #5 clk = ~clk;

   rec_t exp_a[$];
   rec_t exp_b[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;

   // Monitor: one expected record per DUT per cycle, compared mid-cycle.
   always @(negedge clk) begin
      rec_t e;
      cyc = cyc + 1;
      if (exp_a.size() > 0) begin
         e = exp_a.pop_front();
         n_checks = n_checks + 1;
         if (act_a !== e) begin
            n_fail = n_fail + 1;
            $display("FAIL dut_a cycle %0d op=%h funct=%h: got state=%0d rec=%h, expected state=%0d rec=%h",
                     cyc, op, funct, act_a.st, act_a, e.st, e);
         end
      end
      if (exp_b.size() > 0) begin
         e = exp_b.pop_front();
         n_checks = n_checks + 1;
         if (act_b !== e) begin
            n_fail = n_fail + 1;
            $display("FAIL dut_b(nobr/noj) cycle %0d op=%h funct=%h: got state=%0d rec=%h, expected state=%0d rec=%h",
                     cyc, op, funct, act_b.st, act_b, e.st, e);
         end
      end
   end

   // ---------------- reference model ----------------
   function automatic rec_t blank(input logic [3:0] st);
      rec_t r;
      r = '0;
      r.st = st;
      return r;
   endfunction

   function automatic cls_e classify(input logic [5:0] o, input logic [5:0] f, input bit sb, input bit sj);
      if (o == 6'h00)
         return (f == 6'h00 || f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2A) ? C_R : C_TRAP;
      if (o == 6'h23) return C_LW;
      if (o == 6'h2B) return C_SW;
      if (o == 6'h08 || o == 6'h0A || o == 6'h0C || o == 6'h0D || o == 6'h0F) return C_IMM;
      if (o == 6'h04 || o == 6'h05) return sb ? C_BR : C_TRAP;
      if (o == 6'h02) return sj ? C_J : C_TRAP;
      return C_TRAP;
   endfunction

   // ADD 000, SLL 001, OR 010, AND 011, SUB 100, LUI 101, SLT 110
   function automatic logic [2:0] alu_r(input logic [5:0] f);
      case (f)
         6'h00:   return 3'b001;
         6'h22:   return 3'b100;
         6'h24:   return 3'b011;
         6'h25:   return 3'b010;
         6'h2A:   return 3'b110;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [2:0] alu_i(input logic [5:0] o);
      case (o)
         6'h0A:   return 3'b110;
         6'h0C:   return 3'b011;
         6'h0D:   return 3'b010;
         6'h0F:   return 3'b101;
         default: return 3'b000;
      endcase
   endfunction

   rec_t gq[$];
   bit   gmr[$];

   task automatic add(input rec_t r, input bit m);
      gq.push_back(r);
      gmr.push_back(m);
   endtask

   // Expand one instruction into its per-cycle expectations and mem_ready values.
   task automatic gen(input logic [5:0] o, input logic [5:0] f, input bit z,
                      input int fw, input int mw, input bit sb, input bit sj);
      rec_t r;
      cls_e c;
      gq.delete();
      gmr.delete();
      c = classify(o, f, sb, sj);
      for (int i = 0; i < fw; i++) begin
         r = blank(4'd1); r.alu_src_b = 2'b01;
         add(r, 1'b0);
      end
      r = blank(4'd1); r.alu_src_b = 2'b01; r.ir_write = 1'b1; r.pc_en = 1'b1;
      add(r, 1'b1);
      r = blank(4'd2); r.alu_src_b = 2'b11;
      add(r, 1'($urandom));
      case (c)
         C_R: begin
            r = blank(4'd7); r.alu_src_a = 1'b1; r.alu_control = alu_r(f); add(r, 1'($urandom));
            r = blank(4'd8); r.reg_write = 1'b1; r.reg_dst = 1'b1; add(r, 1'($urandom));
         end
         C_IMM: begin
            r = blank(4'd9); r.alu_src_a = 1'b1; r.alu_src_b = 2'b10; r.alu_control = alu_i(o);
            r.imm_zext = (o == 6'h0C || o == 6'h0D); add(r, 1'($urandom));
            r = blank(4'd10); r.reg_write = 1'b1; add(r, 1'($urandom));
         end
         C_LW: begin
            r = blank(4'd3); r.alu_src_a = 1'b1; r.alu_src_b = 2'b10; add(r, 1'($urandom));
            r = blank(4'd4); r.iord = 1'b1;
            for (int i = 0; i < mw; i++) add(r, 1'b0);
            add(r, 1'b1);
            r = blank(4'd5); r.mem_to_reg = 1'b1; r.reg_write = 1'b1; add(r, 1'($urandom));
         end
         C_SW: begin
            r = blank(4'd3); r.alu_src_a = 1'b1; r.alu_src_b = 2'b10; add(r, 1'($urandom));
            r = blank(4'd6); r.iord = 1'b1; r.mem_write = 1'b1;
            for (int i = 0; i < mw; i++) add(r, 1'b0);
            add(r, 1'b1);
         end
         C_BR: begin
            r = blank(4'd11); r.alu_src_a = 1'b1; r.alu_control = 3'b100; r.pc_src = 2'b01;
            r.pc_en = (o == 6'h04) ? z : ~z; add(r, 1'($urandom));
         end
         C_J: begin
            r = blank(4'd12); r.pc_src = 2'b10; r.pc_en = 1'b1; add(r, 1'($urandom));
         end
         default: begin
            r = blank(4'd13); r.illegal = 1'b1; add(r, 1'($urandom));
         end
      endcase
   endtask

   task automatic step(input rec_t ea, input rec_t eb);
      exp_a.push_back(ea);
      exp_b.push_back(eb);
      @(posedge clk);
      #1;
   endtask

   // Run one instruction on both DUTs; optionally hit reset on the final MEMWR cycle.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input bit z,
                            input int fw, input int mw, input bit rst_mid);
      rec_t qa[$];
      rec_t qb[$];
      bit   qm[$];
      gen(o, f, z, fw, mw, 1'b1, 1'b1);
      qa = gq; qm = gmr;
      gen(o, f, z, fw, mw, 1'b0, 1'b0);
      qb = gq;
      op = o; funct = f; zero = z;
      if (qa.size() != qb.size()) begin
         $display("FAIL model_length: dut_a trace %0d vs dut_b trace %0d", qa.size(), qb.size());
         n_fail = n_fail + 1;
         return;
      end
      for (int i = 0; i < qa.size(); i++) begin
         if (rst_mid && i == qa.size() - 1) begin
            reset = 1'b1; mem_ready = 1'b0;
            step(qa[i], qb[i]);
            reset = 1'b0; mem_ready = 1'($urandom);
            step(blank(4'd0), blank(4'd0));
            return;
         end
         mem_ready = qm[i];
         step(qa[i], qb[i]);
      end
   endtask

   logic [5:0] op_tab [12];
   logic [5:0] fn_tab [7];

   initial begin
      int k;
      logic [5:0] o, f;
      op_tab = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h04, 6'h05, 6'h02, 6'h00};
      fn_tab = '{6'h00, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h20};

      // Reset: IDLE while reset high and for the cycle after release.
      reset = 1'b1;
      @(posedge clk); #1;
      step(blank(4'd0), blank(4'd0));
      reset = 1'b0;
      step(blank(4'd0), blank(4'd0));

      // Directed cases.
      run_instr(6'h00, 6'h20, 1'b0, 0, 0, 1'b0);   // ADD
      run_instr(6'h23, 6'h00, 1'b0, 0, 2, 1'b0);   // LW, two MEMRD waits
      run_instr(6'h05, 6'h00, 1'b0, 0, 0, 1'b0);   // BNE taken
      run_instr(6'h05, 6'h00, 1'b1, 0, 0, 1'b0);   // BNE not taken
      run_instr(6'h04, 6'h00, 1'b0, 0, 0, 1'b0);   // BEQ not taken
      run_instr(6'h04, 6'h00, 1'b1, 0, 0, 1'b0);   // BEQ taken
      run_instr(6'h0D, 6'h00, 1'b0, 0, 0, 1'b0);   // ORI
      run_instr(6'h3F, 6'h00, 1'b0, 0, 0, 1'b0);   // illegal op
      run_instr(6'h00, 6'h03, 1'b0, 0, 0, 1'b0);   // illegal funct
      run_instr(6'h02, 6'h00, 1'b0, 0, 0, 1'b0);   // J (traps on dut_b)
      run_instr(6'h00, 6'h22, 1'b0, 3, 0, 1'b0);   // SUB after 3 fetch waits
      run_instr(6'h2B, 6'h00, 1'b0, 0, 2, 1'b0);   // SW, two MEMWR waits
      run_instr(6'h2B, 6'h00, 1'b0, 1, 2, 1'b1);   // SW, reset during MEMWR wait
      run_instr(6'h0F, 6'h00, 1'b0, 0, 0, 1'b0);   // LUI after reset

      // Randomised instruction stream.
      for (int n = 0; n < 300; n++) begin
         k = $urandom_range(0, 13);
         o = (k < 12) ? op_tab[k] : 6'($urandom);
         k = $urandom_range(0, 7);
         f = (k < 7) ? fn_tab[k] : 6'($urandom);
         run_instr(o, f, 1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                   int'($urandom_range(0, 2)), ($urandom_range(0, 40) == 0) && (o == 6'h2B));
      end

      // Let the monitor drain; a leftover expectation is a failure.
      for (int i = 0; i < 4 && (exp_a.size() > 0 || exp_b.size() > 0); i++) @(posedge clk);
      n_checks = n_checks + 1;
      if (exp_a.size() != 0 || exp_b.size() != 0) begin
         n_fail = n_fail + 1;
         $display("FAIL drain: %0d/%0d expectations left, required 0", exp_a.size(), exp_b.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
